// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Holds the flush FSM encoding and the 2-bit direction counter update.
package btb_pkg;

    typedef enum logic [0:0] {
        BTB_IDLE  = 1'b0,
        BTB_FLUSH = 1'b1
    } btb_state_e;

    localparam logic [1:0] CNT_WEAK_T = 2'b10;
    localparam logic [1:0] CNT_MAX    = 2'b11;

    function automatic logic [1:0] cnt_sat(input logic [1:0] cnt,
                                           input logic       up);
        if (up)
            return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU state for a single BTB set.
// Each bit points toward the less recently used half of its subtree.
module btb_plru #(
    parameter int WAYS  = 2,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    localparam int BITS = (WAYS > 1) ? WAYS - 1 : 1;

    logic [BITS-1:0] bits_q;
    logic [BITS-1:0] bits_d;

    generate
        if (WAYS == 4) begin : g_four
            always_comb begin
                bits_d = bits_q;
                if (touch_en) begin
                    bits_d[0] = ~touch_way[1];
                    if (touch_way[1])
                        bits_d[2] = ~touch_way[0];
                    else
                        bits_d[1] = ~touch_way[0];
                end
            end
            assign victim_way = {bits_q[0],
                                 bits_q[0] ? bits_q[2] : bits_q[1]};
        end else if (WAYS == 2) begin : g_two
            always_comb begin
                bits_d = bits_q;
                if (touch_en)
                    bits_d[0] = ~touch_way[0];
            end
            assign victim_way = bits_q[0];
        end else begin : g_one
            logic unused_touch;
            assign unused_touch = ^{touch_en, touch_way, bits_q};
            assign bits_d       = '0;
            assign victim_way   = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bits_q <= '0;
        else if (clear)
            bits_q <= '0;
        else
            bits_q <= bits_d;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters and tree-PLRU.
// IF looks up combinationally; EX trains; a flush sweeps one set per cycle.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int TAG_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        hit_if,
    output logic        taken_if,
    output logic [31:0] target_if,
    input  logic        update_en,
    input  logic [31:0] pc_ex,
    input  logic        taken_ex,
    input  logic [31:0] target_ex,
    input  logic        flush_req,
    output logic        flush_busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    function automatic logic [IDX_W-1:0] hash_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2];
    endfunction

    function automatic logic [TAG_W-1:0] hash_tag(input logic [31:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

    logic [SETS-1:0][WAYS-1:0] valid;
    logic [TAG_W-1:0]          tag_q [SETS][WAYS];
    logic [31:0]               tgt_q [SETS][WAYS];
    logic [1:0]                cnt_q [SETS][WAYS];
    logic [WAY_W-1:0]          victim [SETS];

    btb_state_e       state;
    logic [IDX_W-1:0] flush_ptr;

    logic [IDX_W-1:0] idx_if, idx_ex;
    logic [TAG_W-1:0] tag_if, tag_ex;
    logic             match_if, match_ex, inv_found;
    logic [WAY_W-1:0] way_if, way_ex, inv_way, wr_way;
    logic             upd_ok, do_hit, do_alloc;
    logic             unused_pc;

    assign unused_pc = ^{pc_if, pc_ex};

    assign idx_if = hash_idx(pc_if);
    assign tag_if = hash_tag(pc_if);
    assign idx_ex = hash_idx(pc_ex);
    assign tag_ex = hash_tag(pc_ex);

    always_comb begin
        match_if = 1'b0;
        way_if   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx_if][w] && tag_q[idx_if][w] == tag_if) begin
                match_if = 1'b1;
                way_if   = WAY_W'(w);
            end
        end
    end

    assign flush_busy = (state == BTB_FLUSH);
    assign hit_if     = match_if & ~flush_busy;
    assign taken_if   = hit_if & cnt_q[idx_if][way_if][1];
    assign target_if  = hit_if ? tgt_q[idx_if][way_if] : 32'h0;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        match_ex  = 1'b0;
        way_ex    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx_ex][w] && tag_q[idx_ex][w] == tag_ex) begin
                match_ex = 1'b1;
                way_ex   = WAY_W'(w);
            end
            if (!valid[idx_ex][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign wr_way   = match_ex  ? way_ex  :
                      inv_found ? inv_way : victim[idx_ex];
    assign upd_ok   = update_en && state == BTB_IDLE && !flush_req;
    assign do_hit   = upd_ok && match_ex;
    assign do_alloc = upd_ok && !match_ex && taken_ex;

    genvar s;
    generate
        for (s = 0; s < SETS; s++) begin : g_set
            btb_plru #(
                .WAYS  (WAYS),
                .WAY_W (WAY_W)
            ) u_plru (
                .clk        (clk),
                .rst        (rst),
                .clear      (flush_busy && flush_ptr == IDX_W'(s)),
                .touch_en   ((do_hit || do_alloc) && idx_ex == IDX_W'(s)),
                .touch_way  (wr_way),
                .victim_way (victim[s])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BTB_IDLE;
            flush_ptr <= '0;
        end else begin
            unique case (state)
                BTB_IDLE: begin
                    if (flush_req) begin
                        state     <= BTB_FLUSH;
                        flush_ptr <= '0;
                    end
                end
                BTB_FLUSH: begin
                    if (flush_ptr == IDX_W'(SETS - 1)) begin
                        state     <= BTB_IDLE;
                        flush_ptr <= '0;
                    end else begin
                        flush_ptr <= flush_ptr + IDX_W'(1);
                    end
                end
                default: state <= BTB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < SETS; i++)
                for (int w = 0; w < WAYS; w++)
                    cnt_q[i][w] <= '0;
        end else if (flush_busy) begin
            valid[flush_ptr] <= '0;
        end else if (do_alloc) begin
            valid[idx_ex][wr_way] <= 1'b1;
            cnt_q[idx_ex][wr_way] <= CNT_WEAK_T;
        end else if (do_hit) begin
            cnt_q[idx_ex][wr_way] <= cnt_sat(cnt_q[idx_ex][wr_way], taken_ex);
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[idx_ex][wr_way] <= tag_ex;
            tgt_q[idx_ex][wr_way] <= target_ex;
        end else if (do_hit && taken_ex) begin
            tgt_q[idx_ex][wr_way] <= target_ex;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc with default parameters.
// Vector table covers training and replacement; hand sequences cover flush/reset.
module tb_btb_assoc;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        hit_if;
    logic        taken_if;
    logic [31:0] target_if;
    logic        update_en;
    logic [31:0] pc_ex;
    logic        taken_ex;
    logic [31:0] target_ex;
    logic        flush_req;
    logic        flush_busy;

    int n_checks = 0;
    int n_fail   = 0;

    btb_assoc #(
        .SETS  (8),
        .WAYS  (2),
        .TAG_W (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_if      (pc_if),
        .hit_if     (hit_if),
        .taken_if   (taken_if),
        .target_if  (target_if),
        .update_en  (update_en),
        .pc_ex      (pc_ex),
        .taken_ex   (taken_ex),
        .target_ex  (target_ex),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        upd;
        logic [31:0] pc_ex;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] pc_if;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic upd, input logic [31:0] pe, input logic tk,
                       input logic [31:0] tg, input logic [31:0] pi,
                       input logic eh, input logic et, input logic [31:0] eg);
        vec_t v;
        v.upd = upd; v.pc_ex = pe; v.tk = tk; v.tgt = tg;
        v.pc_if = pi; v.e_hit = eh; v.e_tk = et; v.e_tgt = eg;
        vt.push_back(v);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic eh, input logic et,
                          input logic [31:0] eg);
        pc_if = pc;
        #1;
        check({name, ".hit"}, 32'(hit_if), 32'(eh));
        check({name, ".taken"}, 32'(taken_if), 32'(et));
        check({name, ".target"}, target_if, eg);
    endtask

    task automatic train(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg);
        @(negedge clk);
        update_en = 1'b1; pc_ex = pc; taken_ex = tk; target_ex = tg;
        @(negedge clk);
        update_en = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1; pc_if = 32'h100; update_en = 1'b0;
        pc_ex = '0; taken_ex = 1'b0; target_ex = '0; flush_req = 1'b0;

        // upd pc_ex tk tgt | pc_if hit taken target
        add(0, 32'h000, 0, 32'h0,    32'h100, 0, 0, 32'h0);
        add(1, 32'h100, 1, 32'h200,  32'h100, 0, 0, 32'h0);
        add(0, 32'h000, 0, 32'h0,    32'h100, 1, 1, 32'h200);
        add(0, 32'h000, 0, 32'h0,    32'h104, 0, 0, 32'h0);
        add(1, 32'h100, 0, 32'h0,    32'h100, 1, 1, 32'h200);
        add(1, 32'h100, 0, 32'h0,    32'h100, 1, 0, 32'h200);
        add(1, 32'h100, 1, 32'h200,  32'h100, 1, 0, 32'h200);
        add(0, 32'h000, 0, 32'h0,    32'h100, 1, 0, 32'h200);
        add(1, 32'h100, 0, 32'h999,  32'h100, 1, 0, 32'h200);
        add(0, 32'h000, 0, 32'h0,    32'h100, 1, 0, 32'h200);
        add(1, 32'h100, 1, 32'h300,  32'h100, 1, 0, 32'h200);
        add(0, 32'h000, 0, 32'h0,    32'h100, 1, 0, 32'h300);
        add(1, 32'h100, 1, 32'h300,  32'h100, 1, 0, 32'h300);
        add(1, 32'h100, 1, 32'h300,  32'h100, 1, 1, 32'h300);
        add(1, 32'h100, 1, 32'h300,  32'h100, 1, 1, 32'h300);
        add(1, 32'h100, 0, 32'h0,    32'h100, 1, 1, 32'h300);
        add(0, 32'h000, 0, 32'h0,    32'h100, 1, 1, 32'h300);
        add(1, 32'h200, 1, 32'h2000, 32'h200, 0, 0, 32'h0);
        add(0, 32'h000, 0, 32'h0,    32'h200, 1, 1, 32'h2000);
        add(1, 32'h400, 1, 32'h4000, 32'h100, 1, 1, 32'h300);
        add(0, 32'h000, 0, 32'h0,    32'h100, 0, 0, 32'h0);
        add(0, 32'h000, 0, 32'h0,    32'h200, 1, 1, 32'h2000);
        add(0, 32'h000, 0, 32'h0,    32'h400, 1, 1, 32'h4000);
        add(1, 32'h800, 0, 32'h8000, 32'h800, 0, 0, 32'h0);
        add(0, 32'h000, 0, 32'h0,    32'h800, 0, 0, 32'h0);
        add(1, 32'h800, 1, 32'h8000, 32'h400, 1, 1, 32'h4000);
        add(0, 32'h000, 0, 32'h0,    32'h200, 0, 0, 32'h0);
        add(0, 32'h000, 0, 32'h0,    32'h400, 1, 1, 32'h4000);
        add(0, 32'h000, 0, 32'h0,    32'h800, 1, 1, 32'h8000);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.flush_busy", 32'(flush_busy), 32'h0);

        foreach (vt[i]) begin
            @(negedge clk);
            update_en = vt[i].upd; pc_ex = vt[i].pc_ex;
            taken_ex = vt[i].tk; target_ex = vt[i].tgt;
            lookup($sformatf("vec%0d", i), vt[i].pc_if,
                   vt[i].e_hit, vt[i].e_tk, vt[i].e_tgt);
        end
        @(negedge clk);
        update_en = 1'b0;

        // Populate sets 1..3 alongside set 0
        train(32'h104, 1'b1, 32'h1040);
        train(32'h108, 1'b1, 32'h1080);
        train(32'h10C, 1'b1, 32'h10C0);
        lookup("pre_flush.s1", 32'h104, 1, 1, 32'h1040);
        lookup("pre_flush.s3", 32'h10C, 1, 1, 32'h10C0);

        // Flush with an update in the same cycle and during the sweep
        @(negedge clk);
        flush_req = 1'b1;
        update_en = 1'b1; pc_ex = 32'h110; taken_ex = 1'b1;
        target_ex = 32'h1100;
        pc_if = 32'h104;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            flush_req = 1'b0;
            pc_ex = (c == 0) ? 32'h110 : 32'h114;
            #1;
            if (c == 0)
                check("flush.busy_rise", 32'(flush_busy), 32'h1);
            if (!flush_busy) begin
                update_en = 1'b0;
                break;
            end
            busy_cnt++;
            check($sformatf("flush.hit_c%0d", c), 32'(hit_if), 32'h0);
        end
        check("flush.busy_cycles", 32'(busy_cnt), 32'd8);

        lookup("post_flush.100", 32'h100, 0, 0, 32'h0);
        lookup("post_flush.104", 32'h104, 0, 0, 32'h0);
        lookup("post_flush.10C", 32'h10C, 0, 0, 32'h0);
        lookup("post_flush.110", 32'h110, 0, 0, 32'h0);
        lookup("post_flush.114", 32'h114, 0, 0, 32'h0);
        lookup("post_flush.400", 32'h400, 0, 0, 32'h0);

        train(32'h104, 1'b1, 32'h1041);
        lookup("post_flush.retrain", 32'h104, 1, 1, 32'h1041);

        // Reset asserted on the third flush cycle
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        check("rflush.busy1", 32'(flush_busy), 32'h1);
        repeat (2) @(negedge clk);
        #1;
        check("rflush.busy3", 32'(flush_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rflush.busy_reset", 32'(flush_busy), 32'h0);
        lookup("rflush.104", 32'h104, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        update_en = 1'b1; pc_ex = 32'h108; taken_ex = 1'b1;
        target_ex = 32'h1081;
        #1;
        check("rflush.busy_after", 32'(flush_busy), 32'h0);
        @(negedge clk);
        update_en = 1'b0;
        lookup("rflush.new_update", 32'h108, 1, 1, 32'h1081);
        lookup("rflush.104_gone", 32'h104, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative Branch Target Buffer with per-entry 2-bit direction counters, tree-PLRU replacement and a sequenced flush. It sits beside the fetch stage: IF queries it combinationally with the fetch PC, and EX trains it with every resolved control-flow instruction. It replaces the 4-entry direct-mapped, taken-only BTB in the front end.

## Interface
- SETS, 8: number of sets; power of two, ≥2; IDX_W = $clog2(SETS)
- WAYS, 2: associativity; one of 1, 2, 4
- TAG_W, 12: partial-tag width; IDX_W ≤ TAG_W ≤ 30-IDX_W
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- pc_if  in  32  fetch PC to look up
- hit_if  out  1  valid matching entry found, not flushing
- taken_if  out  1  hit_if and counter MSB = 1
- target_if  out  32  stored target on hit, else 0
- update_en  in  1  EX resolved a branch/jal/jalr this cycle
- pc_ex  in  32  PC of resolved instruction
- taken_ex  in  1  actual direction (1 for jal/jalr)
- target_ex  in  32  actual target
- flush_req  in  1  one-cycle pulse: invalidate the whole BTB
- flush_busy  out  1  flush sweep in progress

## Operation
- Hash: idx = pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; same function on pc_if and pc_ex.
- Entry: valid, tag, target[31:0], cnt[1:0]. Per set: WAYS-1 PLRU bits (0 bits when WAYS=1).
- Lookup: compare tag in all ways of set idx_if; at most one way matches (allocation guarantees this); hit_if = match & ~flush_busy.
- Update, EX hit (same set/tag matches): cnt saturating +1 if taken_ex, -1 otherwise (bounds 0 and 3); target overwritten only if taken_ex; PLRU touched to this way.
- Update, EX miss and taken_ex: allocate the lowest-numbered invalid way, else the PLRU victim; write tag, target_ex, cnt = 2'b10 (weakly taken), valid = 1; PLRU touched to that way.
- Update, EX miss and not taken: no state change.
- FSM IDLE -> FLUSH on flush_req in IDLE; FLUSH clears valid and PLRU of set flush_ptr, flush_ptr++; at flush_ptr = SETS-1 clears the last set and returns to IDLE.
- flush_req while in FLUSH: ignored. update_en while in FLUSH, or in the same cycle as an accepted flush_req: dropped.

## Timing
- Lookup is purely combinational: same-cycle response to pc_if.
- Update writes at posedge; visible to lookup the following cycle. Same-cycle lookup of the entry being updated returns pre-update contents.
- Flush: flush_busy rises the cycle after flush_req is sampled, stays high exactly SETS cycles, falls with the FSM back in IDLE; first update accepted on the cycle flush_busy is low.
- Reset values: hit_if 0, taken_if 0, target_if 0, flush_busy 0; all valid bits 0, all PLRU bits 0, cnt 0, FSM IDLE, flush_ptr 0. Tag/target storage need not be reset (gated by valid).
- Reset asserted mid-flush: FSM immediately to IDLE, all valid cleared; no residual flush_busy.

## Structure
- Package btb_pkg: FSM state enum (BTB_IDLE, BTB_FLUSH), counter constants (CNT_WEAK_T = 2'b10, CNT_MAX = 2'b11), saturating-update function.
- Sub-module btb_plru: per-set tree-PLRU, parametrised on WAYS; inputs touch_en, touch_way; output victim_way; pure state and combinational victim select, no set indexing inside.
- Storage arrays are flop-based; the flush FSM and flush_ptr live in the top module.

## Test plan
- Defaults; reset, then lookup 0x0000_0100 -> hit_if 0, target_if 0, flush_busy 0.
- update pc_ex 0x100 taken target 0x200; next cycle lookup 0x100 -> hit 1, taken 1 (cnt 2), target 0x200; lookup 0x104 -> hit 0.
- Two not-taken updates of 0x100 -> cnt 0, taken_if 0, hit_if 1, target still 0x200; third taken update -> cnt 1, taken_if 0, target 0x200 unchanged only if target_ex equal.
- Taken updates 0x100, 0x200, 0x400 (all set 0, WAYS=2): 0x400 evicts 0x100 (PLRU); lookups: 0x100 miss, 0x200 and 0x400 hit.
- Populate 4 sets, pulse flush_req: flush_busy high exactly 8 cycles, hit_if 0 throughout; update_en during flush dropped; all lookups miss afterwards.
- Assert rst on 3rd flush cycle -> flush_busy 0 next sample, all lookups miss, new update accepted immediately after reset release.
